// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT peak-finder datapath.
package fft_pkg;

  localparam int unsigned FRAMESIZE_DEFAULT  = 1024;
  localparam int unsigned DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned BIN_W              = $clog2(FRAMESIZE_DEFAULT);
  localparam int unsigned MAG_W              = 2 * DATA_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    StAccum,
    StDrain,
    StReport
  } peak_state_t;

  typedef struct packed {
    logic signed [DATA_WIDTH_DEFAULT-1:0] im;
    logic signed [DATA_WIDTH_DEFAULT-1:0] re;
  } complex_bin_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage pipelined |X|^2 unit: registers re/im, then registers re^2 and im^2.
// The final sum is combinational so a consumer can compare it in its own stage.
module fft_mag_sq #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned IdxWidth  = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [DataWidth-1:0]   re_i,
  input  logic [DataWidth-1:0]   im_i,
  input  logic [IdxWidth-1:0]    idx_i,
  output logic                   valid_o,
  output logic [IdxWidth-1:0]    idx_o,
  output logic [2*DataWidth-1:0] mag_o
);

  localparam int unsigned MagW = 2 * DataWidth;

  logic                 s1_valid_q;
  logic [DataWidth-1:0] s1_re_q, s1_im_q;
  logic [IdxWidth-1:0]  s1_idx_q;
  logic                 s2_valid_q;
  logic [MagW-1:0]      s2_re_sq_q, s2_im_sq_q;
  logic [IdxWidth-1:0]  s2_idx_q;

  logic signed [MagW-1:0] re_x, im_x, re_sq, im_sq;

  // Sign-extend to full product width so the square is exact.
  assign re_x  = {{DataWidth{s1_re_q[DataWidth-1]}}, s1_re_q};
  assign im_x  = {{DataWidth{s1_im_q[DataWidth-1]}}, s1_im_q};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_re_sq_q <= '0;
      s2_im_sq_q <= '0;
      s2_idx_q   <= '0;
    end else begin
      s1_valid_q <= valid_i & ~flush_i;
      s1_re_q    <= re_i;
      s1_im_q    <= im_i;
      s1_idx_q   <= idx_i;
      s2_valid_q <= s1_valid_q & ~flush_i;
      s2_re_sq_q <= re_sq;
      s2_im_sq_q <= im_sq;
      s2_idx_q   <= s1_idx_q;
    end
  end

  assign valid_o = s2_valid_q;
  assign idx_o   = s2_idx_q;
  assign mag_o   = s2_re_sq_q + s2_im_sq_q;

endmodule

// File: rtl/fft_peak_finder.sv
// Per-frame peak search over |X|^2 of the positive-frequency half of an FFT stream.
// Reports (bin, magnitude) four cycles after the last beat of each well-formed frame.
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int unsigned FRAMESIZE  = FRAMESIZE_DEFAULT,
  parameter int unsigned MIN_BIN    = 1,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                         clk_100mhz,
  input  logic                         rst,
  input  logic [2*DATA_WIDTH-1:0]      fft_out_data,
  input  logic                         fft_out_valid,
  input  logic                         fft_out_last,
  output logic                         fft_out_ready,
  output logic [$clog2(FRAMESIZE)-1:0] peak_bin,
  output logic [2*DATA_WIDTH-1:0]      peak_mag,
  output logic                         peak_valid,
  output logic                         frame_error
);

  localparam int unsigned BinW = $clog2(FRAMESIZE);
  localparam int unsigned MagW = 2 * DATA_WIDTH;

  peak_state_t     state_q, state_d;
  logic [BinW-1:0] cnt_q, cnt_d;
  logic [1:0]      drain_q, drain_d;
  logic [BinW-1:0] max_bin_q, max_bin_d;
  logic [MagW-1:0] max_mag_q, max_mag_d;
  logic [BinW-1:0] peak_bin_q, peak_bin_d;
  logic [MagW-1:0] peak_mag_q, peak_mag_d;
  logic            peak_valid_q, peak_valid_d;
  logic            frame_error_q, frame_error_d;

  logic            accept, at_end, err, eligible;
  logic            ms_valid;
  logic [BinW-1:0] ms_idx;
  logic [MagW-1:0] ms_mag;

  assign fft_out_ready = (state_q == StAccum);
  assign accept        = fft_out_valid & fft_out_ready;
  assign at_end        = (cnt_q == BinW'(FRAMESIZE - 1));
  // Either an early last or a missing last at the final bin breaks framing.
  assign err           = accept & (fft_out_last != at_end);

  fft_mag_sq #(
    .DataWidth(DATA_WIDTH),
    .IdxWidth (BinW)
  ) u_mag_sq (
    .clk_i  (clk_100mhz),
    .rst_i  (rst),
    .flush_i(err),
    .valid_i(accept),
    .re_i   (fft_out_data[DATA_WIDTH-1:0]),
    .im_i   (fft_out_data[2*DATA_WIDTH-1:DATA_WIDTH]),
    .idx_i  (cnt_q),
    .valid_o(ms_valid),
    .idx_o  (ms_idx),
    .mag_o  (ms_mag)
  );

  assign eligible = ms_valid && (ms_idx >= BinW'(MIN_BIN))
                    && (ms_idx <= BinW'(FRAMESIZE / 2 - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    max_bin_d     = max_bin_q;
    max_mag_d     = max_mag_q;
    peak_bin_d    = peak_bin_q;
    peak_mag_d    = peak_mag_q;
    peak_valid_d  = 1'b0;
    frame_error_d = err;

    // Strict compare: on a tie the earlier (lower) bin is kept.
    if (eligible && (ms_mag > max_mag_q)) begin
      max_bin_d = ms_idx;
      max_mag_d = ms_mag;
    end

    unique case (state_q)
      StAccum: begin
        if (err) begin
          cnt_d     = '0;
          max_bin_d = BinW'(MIN_BIN);
          max_mag_d = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (fft_out_last) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 2'd2) begin
          state_d      = StReport;
          peak_bin_d   = max_bin_q;
          peak_mag_d   = max_mag_q;
          peak_valid_d = 1'b1;
        end
      end
      StReport: begin
        state_d   = StAccum;
        cnt_d     = '0;
        max_bin_d = BinW'(MIN_BIN);
        max_mag_d = '0;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q       <= StAccum;
      cnt_q         <= '0;
      drain_q       <= '0;
      max_bin_q     <= BinW'(MIN_BIN);
      max_mag_q     <= '0;
      peak_bin_q    <= BinW'(MIN_BIN);
      peak_mag_q    <= '0;
      peak_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      max_bin_q     <= max_bin_d;
      max_mag_q     <= max_mag_d;
      peak_bin_q    <= peak_bin_d;
      peak_mag_q    <= peak_mag_d;
      peak_valid_q  <= peak_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;
  assign peak_valid  = peak_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder with FRAMESIZE=32, MIN_BIN=1, DATA_WIDTH=16.
module tb_fft_peak_finder;

  localparam int FS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fft_out_data;
  logic        fft_out_valid, fft_out_last, fft_out_ready;
  logic [4:0]  peak_bin;
  logic [31:0] peak_mag;
  logic        peak_valid, frame_error;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;
  int pv_cyc = 0, fe_cyc = 0;
  int pv_count = 0, fe_count = 0, rdy_low = 0;
  logic [4:0]  pv_bin = '0;
  logic [31:0] pv_mag = '0;

  logic signed [15:0] re_a [FS];
  logic signed [15:0] im_a [FS];

  fft_peak_finder #(
    .FRAMESIZE (32),
    .MIN_BIN   (1),
    .DATA_WIDTH(16)
  ) dut (
    .clk_100mhz   (clk),
    .rst          (rst),
    .fft_out_data (fft_out_data),
    .fft_out_valid(fft_out_valid),
    .fft_out_last (fft_out_last),
    .fft_out_ready(fft_out_ready),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .peak_valid   (peak_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (peak_valid) begin
      pv_count <= pv_count + 1;
      pv_cyc   <= cyc;
      pv_bin   <= peak_bin;
      pv_mag   <= peak_mag;
    end
    if (frame_error) begin
      fe_count <= fe_count + 1;
      fe_cyc   <= cyc;
    end
    if (!fft_out_ready) rdy_low <= rdy_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < FS; i++) begin
      re_a[i] = '0;
      im_a[i] = '0;
    end
  endtask

  task automatic send_beat(input int i, input bit last);
    int w;
    w = 0;
    while (!fft_out_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    fft_out_valid = 1'b1;
    fft_out_data  = {im_a[i], re_a[i]};
    fft_out_last  = last;
    last_cyc      = cyc;
    @(posedge clk); #1;
    fft_out_valid = 1'b0;
    fft_out_last  = 1'b0;
  endtask

  // During gaps, last is driven high without valid; it must be ignored.
  task automatic send_frame(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        fft_out_last = 1'b1;
        @(posedge clk); #1;
        fft_out_last = 1'b0;
      end
      send_beat(i, i == last_at);
    end
  endtask

  task automatic expect_report(input logic [31:0] exp_bin, input logic [31:0] exp_mag,
                               input int pv_before, input int rdy_before);
    repeat (10) @(posedge clk);
    #1;
    check("report_count", pv_count - pv_before, 1);
    check("report_latency", pv_cyc - last_cyc, 4);
    check("peak_bin", {27'd0, pv_bin}, exp_bin);
    check("peak_mag", pv_mag, exp_mag);
    check("ready_low_cycles", rdy_low - rdy_before, 4);
    check("peak_bin_hold", {27'd0, peak_bin}, exp_bin);
  endtask

  initial begin
    int pv0, rd0, fe0;
    rst           = 1'b1;
    fft_out_valid = 1'b0;
    fft_out_last  = 1'b0;
    fft_out_data  = '0;
    clear_frame();
    #1;
    check("rst_ready", {31'd0, fft_out_ready}, 1);
    check("rst_peak_bin", {27'd0, peak_bin}, 1);
    check("rst_peak_mag", peak_mag, 0);
    check("rst_peak_valid", {31'd0, peak_valid}, 0);
    check("rst_frame_error", {31'd0, frame_error}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single tone at bin 5.
    clear_frame();
    re_a[5] = 16'sd100;
    pv0 = pv_count; rd0 = rdy_low;
    send_frame(FS, FS - 1, 1'b0);
    expect_report(5, 10000, pv0, rd0);

    // DC and upper-half energy must not win.
    clear_frame();
    re_a[0]  = 16'sd30000;
    re_a[20] = 16'sd20000;
    im_a[20] = 16'sd20000;
    re_a[7]  = 16'sd3;
    im_a[7]  = 16'sd4;
    pv0 = pv_count; rd0 = rdy_low;
    send_frame(FS, FS - 1, 1'b0);
    expect_report(7, 25, pv0, rd0);

    // Tie between bins 3 and 9 with random gaps.
    clear_frame();
    re_a[3] = -16'sd50;
    im_a[3] = 16'sd50;
    re_a[9] = -16'sd50;
    im_a[9] = 16'sd50;
    pv0 = pv_count; rd0 = rdy_low;
    send_frame(FS, FS - 1, 1'b1);
    expect_report(3, 5000, pv0, rd0);

    // Early last on beat 20, then a good frame peaking at bin 12.
    clear_frame();
    re_a[5] = 16'sd1000;
    pv0 = pv_count; rd0 = rdy_low; fe0 = fe_count;
    send_frame(21, 20, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("early_last_error_count", fe_count - fe0, 1);
    check("early_last_error_timing", fe_cyc - last_cyc, 1);
    check("early_last_no_report", pv_count - pv0, 0);
    check("early_last_ready_high", rdy_low - rd0, 0);
    check("early_last_peak_held", {27'd0, peak_bin}, 3);
    clear_frame();
    re_a[12] = 16'sd100;
    im_a[12] = 16'sd100;
    pv0 = pv_count; rd0 = rdy_low;
    send_frame(FS, FS - 1, 1'b0);
    expect_report(12, 20000, pv0, rd0);

    // Final bin without last wraps the counter and discards the frame.
    clear_frame();
    re_a[6] = 16'sd7;
    pv0 = pv_count; fe0 = fe_count;
    send_frame(FS, -1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("missing_last_error_count", fe_count - fe0, 1);
    check("missing_last_no_report", pv_count - pv0, 0);
    check("missing_last_peak_mag_held", peak_mag, 20000);

    // Reset mid-frame after a strong bin 4, then a clean frame.
    clear_frame();
    re_a[4] = 16'sd200;
    send_frame(10, -1, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_peak_bin", {27'd0, peak_bin}, 1);
    check("midrst_peak_mag", peak_mag, 0);
    check("midrst_ready", {31'd0, fft_out_ready}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_frame();
    re_a[2] = 16'sd10;
    im_a[2] = 16'sd10;
    pv0 = pv_count; rd0 = rdy_low;
    send_frame(FS, FS - 1, 1'b0);
    expect_report(2, 200, pv0, rd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Sits directly downstream of the Hann-window/FFT chain in the autotuner datapath.
- Consumes the complex FFT output stream one bin per beat and computes |X|² per bin.
- Tracks the largest-magnitude bin in the positive-frequency half, excluding DC.
- Once per frame, reports the peak bin index and its magnitude to the pitch-estimation logic.

Parameters:
- FRAMESIZE, 1024, FFT points per frame (power of 2, ≥ 8); bench uses 32
- MIN_BIN, 1, lowest bin eligible for peak (skips DC/hum); must be < FRAMESIZE/2
- DATA_WIDTH, 16, width of each signed real/imag component

Ports:
- clk_100mhz  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- fft_out_data  in  2*DATA_WIDTH  complex bin; [DATA_WIDTH-1:0] = re (signed), upper half = im (signed)
- fft_out_valid  in  1  bin valid (AXI-stream tvalid semantics)
- fft_out_last  in  1  marks bin FRAMESIZE-1
- fft_out_ready  out  1  block can accept a beat
- peak_bin  out  $clog2(FRAMESIZE)  index of max-magnitude bin of last completed frame
- peak_mag  out  2*DATA_WIDTH  re²+im² of that bin, unsigned
- peak_valid  out  1  one-cycle pulse when peak_bin/peak_mag update
- frame_error  out  1  one-cycle pulse on framing mismatch

Behaviour:
- Reset: async clear, effective immediately. Values:
  - state = ACCUM, bin counter = 0
  - fft_out_ready = 1, peak_bin = MIN_BIN, peak_mag = 0
  - peak_valid = 0, frame_error = 0
  - pipeline valid bits = 0, running max cleared
- Reset mid-frame discards the partial frame; peak outputs return to their reset values.
- Accept: a beat is accepted when fft_out_valid && fft_out_ready.
  - Bin counter increments per accepted beat.
  - The accepted beat's bin index = counter value before increment.
- Pipeline, 3 stages, each carrying a valid bit and bin index:
  - S1 registers re, im, index.
  - S2 registers re² and im², signed multiply giving 2*DATA_WIDTH-bit products.
  - S3 adds them into an unsigned 2*DATA_WIDTH-bit sum (max 2^31, no overflow) and compares with the running max.
- Running max update: only when MIN_BIN ≤ index ≤ FRAMESIZE/2-1 and sum > max.
  - The comparison is strict, so ties keep the lower bin.
  - An all-zero frame reports bin MIN_BIN, mag 0.
  - The upper half of the frame passes through the pipeline but is ignored.
- FSM states: ACCUM → DRAIN → REPORT → ACCUM.
  - ACCUM: ready = 1. An accepted beat with last at cycle t, while counter == FRAMESIZE-1, moves to DRAIN.
  - DRAIN: cycles t+1..t+3, ready = 0, pipeline flushes.
  - REPORT: cycle t+4, ready = 0.
    - peak_bin/peak_mag load the running max and peak_valid = 1.
    - The running max resets to (MIN_BIN, 0) and the counter resets to 0.
    - The next cycle, t+5, returns to ACCUM with ready = 1.
- Peak outputs hold between reports.
- Latency: last accepted beat to peak_valid = 4 cycles. Minimum frame period = FRAMESIZE + 4 cycles.
- Framing errors pulse frame_error for one cycle, the registered cycle after the offending accept, and stay in ACCUM:
  - last arriving with counter != FRAMESIZE-1: discard the frame (running max and counter reset, pipeline contents invalidated); peak outputs unchanged.
  - counter == FRAMESIZE-1 accepted without last: the counter wraps to 0 and the frame is discarded the same way.
- fft_out_valid low mid-frame: the pipeline simply bubbles; no timeout.
- fft_out_last without fft_out_valid is ignored.

Decomposition:
- Package fft_pkg:
  - FRAMESIZE default, DATA_WIDTH, BIN_W = $clog2(FRAMESIZE), MAG_W = 2*DATA_WIDTH
  - typedef peak_state_t enum {ACCUM, DRAIN, REPORT}
  - typedef complex_bin_t struct {signed im, signed re}
- Sub-module fft_mag_sq: the 2-stage pipelined re²+im² unit with valid/index passthrough. Reusable by the spectrum display path.

Test Plan (FRAMESIZE=32, MIN_BIN=1):
- Frame with bin 5 = (re 100, im 0), all others 0, valid every cycle:
  - peak_valid pulses 4 cycles after last, peak_bin = 5, peak_mag = 10000.
  - ready is low for exactly 4 cycles.
- Bin 0 = (30000, 0), bin 20 = (20000, 20000), bin 7 = (3, 4), rest 0:
  - peak_bin = 7, peak_mag = 25.
  - DC and upper-half bins are ignored.
- Bins 3 and 9 both (−50, 50), rest 0, with random valid gaps:
  - peak_bin = 3, peak_mag = 5000.
  - Tie resolves to the lower bin; gaps do not change the result.
- last asserted on beat 20, followed by a correct frame peaking at bin 12 (100, 100):
  - frame_error pulses once.
  - No peak_valid for the bad frame, then peak_bin = 12, peak_mag = 20000.
- rst pulsed at beat 10 of a frame whose earlier bins peak at bin 4:
  - Outputs read back to their reset values (peak_bin 1, peak_mag 0).
  - The next full frame reports correctly, with no stale peak from bin 4.
